button_cmd_encoder: RTL and testbench
=====================================

# button_cmd_encoder

Input stage for the 2-bit command FSM. Synchronizes and debounces two raw push-buttons, merges near-simultaneous presses into a chord, and emits exactly one single-cycle 2-bit command per press gesture. Its `cmd` output drives the FSM's `in` port directly: idle code 00, one-cycle command pulses 01/10/11.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4. Consecutive stable cycles a synchronized button must hold a new level before it is accepted. Legal range ≥1.
- `CHORD_CYCLES`, default 2. Cycles spent waiting for the second button after the first is accepted. Legal range ≥1.

Ports (one clock; reset is synchronous and active-high):
- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high; clears all state.
- `btn_raw`  input  2  asynchronous raw buttons; bit0 = A, bit1 = B; 1 = pressed.
- `cmd`  output  2  command code; 00 when idle; 01/10/11 for exactly one cycle per gesture.
- `cmd_valid`  output  1  high exactly when `cmd` != 00.
- `busy`  output  1  high in any state other than IDLE.

## Operation
- **Synchronizer.** Each button passes through a 2-FF synchronizer (`s1`, `s2`).
- **Debouncer, per button.** Holds `db` and a counter `cnt`.
  - If `s2 == db`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `db <= s2` and `cnt <= 0`.
  - Else: `cnt++`.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles at `s2` never changes `db`.
  - Counter width is `$clog2(DEBOUNCE_CYCLES+1)`. It saturates logically and never wraps.
- **FSM states:** IDLE, CHORD, EMIT, WAIT_REL. The FSM holds `code_q[1:0]` and a timer `tmr`.
  - **IDLE**
    - `db == 11`: `code_q <= 11`, go to EMIT.
    - `db` is 01 or 10: `code_q <= db`, `tmr <= 0`, go to CHORD.
    - `db == 00`: stay.
  - **CHORD**
    - `code_q <= code_q | db`.
    - If `(code_q | db) == 11` or `tmr == CHORD_CYCLES-1`: go to EMIT.
    - Else: `tmr++`.
    - A release during CHORD does not cancel the gesture; the latched code is still emitted.
  - **EMIT:** lasts exactly one cycle, then unconditionally go to WAIT_REL.
  - **WAIT_REL:** go to IDLE when `db == 00`. No new command is possible until both buttons are released.
- **Outputs.** Decoded from registered state only (no combinational path from `btn_raw`):
  - `cmd = (state == EMIT) ? code_q : 00`
  - `cmd_valid = (state == EMIT)`
  - `busy = (state != IDLE)`

## Timing
- **Reset values.** `s1`, `s2`, `db`, `cnt`, `tmr`, `code_q` = 0; state = IDLE. Hence `cmd = 00`, `cmd_valid = 0`, `busy = 0` in the cycle after reset is sampled.
- **Press to accepted level.** If `btn_raw` rises before edge k and stays stable:
  - `s2` is high after edge k+1.
  - `db` is high after edge k+1+DEBOUNCE_CYCLES.
- **Single press to command.**
  - The FSM enters CHORD on the edge after `db` rises.
  - It spends CHORD_CYCLES cycles in CHORD.
  - It is in EMIT for one cycle.
  - Total from raw edge to `cmd` asserted: DEBOUNCE_CYCLES + CHORD_CYCLES + 3 cycles (9 at defaults).
- **Chord.** The second `db` rising while in CHORD shortens the wait: EMIT follows on the next edge with code 11. Both `db` rising on the same cycle in IDLE goes directly to EMIT with code 11.
- **Reset mid-operation.** Any state returns to IDLE on the next edge. A pending chord is dropped and no command is emitted.
- **Buttons held through reset.** After deassertion they re-debounce from `db = 0` and produce one fresh command.
- **Release timing.**
  - Release followed by re-press during WAIT_REL: no command.
  - Release followed by re-press after IDLE is reached: new gesture.

## Structure
- **Package `cmd_pkg`:**
  - `typedef enum logic [1:0] {IDLE, CHORD, EMIT, WAIT_REL} enc_state_t`
  - Code constants `CMD_NONE = 2'b00`, `CMD_A = 2'b01`, `CMD_B = 2'b10`, `CMD_AB = 2'b11`
  - The command FSM imports the same constants.
- **Sub-module `debouncer`:**
  - Parameter `DEBOUNCE_CYCLES`; ports `clk`, `reset`, `raw`, `db`.
  - Contains the synchronizer and counter.
  - Instantiated twice.

## Test plan
All scenarios use the default parameters (`DEBOUNCE_CYCLES` = 4, `CHORD_CYCLES` = 2).
- **Reset.** Hold `reset` 2 cycles with `btn_raw = 11` → `cmd = 00` and `busy = 0` throughout reset. Then exactly one `cmd = 11` pulse after release.
- **Single A press.** Raise `btn_raw[0]`, hold 20 cycles → `cmd = 01` for exactly one cycle, 9 cycles after the raw edge. Nothing further until release.
- **Chord.** Raise A, then raise B 2 cycles later → single `cmd = 11` pulse. No 01 pulse is ever emitted.
- **Glitch rejection.** Pulse `btn_raw[1]` high for 3 cycles → `db` never rises, `cmd` stays 00, `busy` stays 0.
- **Hold and repeat.**
  - Press B, hold, pulse A during WAIT_REL → no extra command.
  - Release both, wait for IDLE, press B again → second `cmd = 10`.
- **Reset during CHORD.** Press A, assert `reset` one cycle while in CHORD → no command emitted, state IDLE. A new press afterwards works normally.

Source files
------------

// File: rtl/cmd_pkg.sv
// -----------------------------------------------------------------------------
// cmd_pkg
// Shared definitions for the button command encoder and the command FSM it
// feeds: encoder state encoding and the 2-bit command codes.
// -----------------------------------------------------------------------------
package cmd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CHORD,
        EMIT,
        WAIT_REL
    } enc_state_t;

    localparam logic [1:0] CMD_NONE = 2'b00;
    localparam logic [1:0] CMD_A    = 2'b01;
    localparam logic [1:0] CMD_B    = 2'b10;
    localparam logic [1:0] CMD_AB   = 2'b11;

endpackage

// File: rtl/debouncer.sv
// -----------------------------------------------------------------------------
// debouncer
// Brings one asynchronous raw button into the clock domain through a 2-FF
// synchronizer, then accepts a new level only after it has been seen on the
// synchronized signal for DEBOUNCE_CYCLES consecutive cycles.
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous, active-high; clears synchronizer, level, counter
//   raw    in   asynchronous raw button (1 = pressed)
//   db     out  debounced, accepted button level
// -----------------------------------------------------------------------------
module debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic db
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            db  <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            // cnt counts consecutive mismatching cycles; any agreement restarts
            // it, so a short glitch can never reach CNT_LAST. It tops out at
            // CNT_LAST and is cleared there, so it never wraps.
            if (s2 == db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                db  <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/button_cmd_encoder.sv
// -----------------------------------------------------------------------------
// button_cmd_encoder
// Input stage for the 2-bit command FSM. Debounces two push-buttons, merges
// presses that land within a short window into a chord, and emits exactly one
// single-cycle command per press gesture. A new gesture is only possible once
// both buttons are released.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high; returns everything to idle
//   btn_raw    in   [1:0] raw buttons, bit0 = A, bit1 = B, 1 = pressed
//   cmd        out  [1:0] 00 idle; 01/10/11 for one cycle per gesture
//   cmd_valid  out  high exactly when cmd != 00
//   busy       out  high whenever a gesture is in progress or awaiting release
// -----------------------------------------------------------------------------
module button_cmd_encoder
    import cmd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CHORD_CYCLES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] btn_raw,
    output logic [1:0] cmd,
    output logic       cmd_valid,
    output logic       busy
);

    localparam int TW = $clog2(CHORD_CYCLES + 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(CHORD_CYCLES - 1);

    logic [1:0]    db;
    enc_state_t    state;
    enc_state_t    state_nx;
    logic [1:0]    code_q;
    logic [1:0]    code_nx;
    logic [TW-1:0] tmr;
    logic [TW-1:0] tmr_nx;
    logic [1:0]    merged;

    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_a (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_raw[0]),
        .db    (db[0])
    );

    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_b (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_raw[1]),
        .db    (db[1])
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            code_q <= CMD_NONE;
            tmr    <= '0;
        end else begin
            state  <= state_nx;
            code_q <= code_nx;
            tmr    <= tmr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        code_nx  = code_q;
        tmr_nx   = tmr;
        merged   = code_q | db;

        case (state)
            IDLE: begin
                if (db == CMD_AB) begin
                    code_nx  = CMD_AB;
                    state_nx = EMIT;
                end else if (db != CMD_NONE) begin
                    code_nx  = db;
                    tmr_nx   = '0;
                    state_nx = CHORD;
                end
            end
            CHORD: begin
                // Code only accumulates: a release inside the window keeps
                // the already-latched button in the gesture.
                code_nx = merged;
                if (merged == CMD_AB || tmr == TMR_LAST) begin
                    state_nx = EMIT;
                end else begin
                    tmr_nx = tmr + TW'(1);
                end
            end
            EMIT: begin
                state_nx = WAIT_REL;
            end
            WAIT_REL: begin
                if (db == CMD_NONE) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Outputs come from registered state only; no path from btn_raw.
    assign cmd       = (state == EMIT) ? code_q : CMD_NONE;
    assign cmd_valid = (state == EMIT);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_button_cmd_encoder.sv
// -----------------------------------------------------------------------------
// tb_button_cmd_encoder
// Directed bench for button_cmd_encoder at default parameters. A reference
// model derives the accepted button levels from a history of sampled raw
// inputs and tracks gestures by edge number; a compare process checks every
// cycle against it, and scenario checks pin pulse counts and timing.
// -----------------------------------------------------------------------------
module tb_button_cmd_encoder;

    localparam int D = 4;
    localparam int C = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] btn_raw = 2'b11;
    logic [1:0] cmd;
    logic       cmd_valid;
    logic       busy;

    always #5 clk = ~clk;

    button_cmd_encoder #(
        .DEBOUNCE_CYCLES (D),
        .CHORD_CYCLES    (C)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_raw),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .busy      (busy)
    );

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;

    // Reference model state
    logic [1:0] hist[$];
    logic [1:0] m_db      = 2'b00;
    bit         g_active  = 1'b0;
    logic [1:0] g_code    = 2'b00;
    int         g_start   = 0;
    int         emit_edge = -1;
    logic [1:0] exp_cmd   = 2'b00;
    bit         exp_busy  = 1'b0;

    // Observed DUT activity
    int pulses[4];
    int last_pulse_edge = -1;
    int busy_seen       = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_n, act, exp);
        end
    endtask

    task automatic cyc(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic clr;
        for (int i = 0; i < 4; i++) pulses[i] = 0;
        busy_seen = 0;
    endtask

    // Model: a button level is accepted once the synchronized input (raw
    // delayed two edges) has disagreed with it for D consecutive samples.
    // A gesture starts from idle on any accepted press, fires at once for a
    // simultaneous pair, otherwise fires after C edges or as soon as both are
    // seen, then waits (from two edges after firing) for both to be released.
    initial begin
        logic [1:0] new_db;
        bit         flip;
        for (int i = 0; i < D + 2; i++) hist.push_back(2'b00);
        forever begin
            @(posedge clk);
            edge_n++;
            if (reset) begin
                hist[hist.size() - 1] = 2'b00;
                hist.push_back(2'b00);
                m_db      = 2'b00;
                g_active  = 1'b0;
                g_code    = 2'b00;
                emit_edge = -1;
                exp_cmd   = 2'b00;
                exp_busy  = 1'b0;
            end else begin
                if (!g_active) begin
                    if (m_db != 2'b00) begin
                        g_active  = 1'b1;
                        g_code    = m_db;
                        g_start   = edge_n;
                        emit_edge = (m_db == 2'b11) ? edge_n : -1;
                    end
                end else if (emit_edge < 0) begin
                    g_code = g_code | m_db;
                    if (g_code == 2'b11 || edge_n == g_start + C) emit_edge = edge_n;
                end else if (edge_n >= emit_edge + 2 && m_db == 2'b00) begin
                    g_active = 1'b0;
                end

                new_db = m_db;
                for (int b = 0; b < 2; b++) begin
                    flip = 1'b1;
                    for (int j = 1; j <= D; j++) begin
                        if (hist[hist.size() - 1 - j][b] == m_db[b]) flip = 1'b0;
                    end
                    if (flip) new_db[b] = ~m_db[b];
                end
                m_db = new_db;
                hist.push_back(btn_raw);
                if (hist.size() > 64) void'(hist.pop_front());

                exp_cmd  = (g_active && emit_edge == edge_n) ? g_code : 2'b00;
                exp_busy = g_active;
            end
        end
    end

    // Per-cycle comparison, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (edge_n >= 1) begin
                chk("cmd", int'(cmd), int'(exp_cmd));
                chk("cmd_valid", int'(cmd_valid), int'(exp_cmd != 2'b00));
                chk("busy", int'(busy), int'(exp_busy));
                if (cmd != 2'b00) begin
                    pulses[cmd]++;
                    last_pulse_edge = edge_n;
                end
                if (busy) busy_seen++;
            end
        end
    end

    initial begin
        int e0;
        clr();

        // Reset held two cycles with both buttons pressed
        reset   = 1'b1;
        btn_raw = 2'b11;
        cyc(2);
        chk("busy_in_reset", int'(busy), 0);
        chk("cmd_in_reset", int'(cmd), 0);
        reset = 1'b0;
        cyc(25);
        chk("reset_ab_pulses", pulses[3], 1);
        chk("reset_other_pulses", pulses[1] + pulses[2], 0);
        chk("reset_ab_edge", last_pulse_edge, 9);
        btn_raw = 2'b00;
        cyc(15);

        // Single A press
        clr();
        btn_raw = 2'b01;
        e0 = edge_n;
        cyc(20);
        chk("single_a_pulses", pulses[1], 1);
        chk("single_a_others", pulses[2] + pulses[3], 0);
        chk("single_a_latency", last_pulse_edge - e0, 9);
        btn_raw = 2'b00;
        cyc(15);

        // Chord: B two cycles after A
        clr();
        btn_raw = 2'b01;
        cyc(2);
        btn_raw = 2'b11;
        cyc(20);
        chk("chord_ab_pulses", pulses[3], 1);
        chk("chord_no_a", pulses[1], 0);
        chk("chord_no_b", pulses[2], 0);
        btn_raw = 2'b00;
        cyc(15);

        // Glitch on B shorter than the debounce window
        clr();
        btn_raw = 2'b10;
        cyc(3);
        btn_raw = 2'b00;
        cyc(15);
        chk("glitch_pulses", pulses[1] + pulses[2] + pulses[3], 0);
        chk("glitch_busy_cycles", busy_seen, 0);

        // Hold B, pulse A during release wait, then a fresh B press
        clr();
        btn_raw = 2'b10;
        cyc(15);
        chk("hold_first_b", pulses[2], 1);
        btn_raw = 2'b11;
        cyc(8);
        btn_raw = 2'b10;
        cyc(6);
        chk("hold_no_extra", pulses[1] + pulses[2] + pulses[3], 1);
        btn_raw = 2'b00;
        cyc(12);
        btn_raw = 2'b10;
        cyc(15);
        chk("repeat_second_b", pulses[2], 2);
        chk("repeat_no_others", pulses[1] + pulses[3], 0);
        btn_raw = 2'b00;
        cyc(15);

        // Reset while waiting for a chord partner
        clr();
        btn_raw = 2'b01;
        cyc(7);
        chk("chord_wait_busy", int'(busy), 1);
        chk("chord_wait_cmd", int'(cmd), 0);
        reset   = 1'b1;
        btn_raw = 2'b00;
        cyc(1);
        chk("after_reset_busy", int'(busy), 0);
        reset = 1'b0;
        cyc(20);
        chk("dropped_chord_pulses", pulses[1] + pulses[2] + pulses[3], 0);
        btn_raw = 2'b01;
        cyc(20);
        chk("post_reset_a", pulses[1], 1);
        btn_raw = 2'b00;
        cyc(15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
